// File: rtl/board_io_pkg.sv
// Shared types for the board I/O controller: LED display modes and the
// SOC reset sequencer states.
package board_io_pkg;

    typedef enum logic [1:0] {
        LED_SOC    = 2'd0,
        LED_STATUS = 2'd1,
        LED_OFF    = 2'd2
    } led_mode_t;

    typedef enum logic {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_t;

    function automatic led_mode_t next_led_mode(input led_mode_t mode);
        case (mode)
            LED_SOC:    return LED_STATUS;
            LED_STATUS: return LED_OFF;
            default:    return LED_SOC;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, optional inversion, stability
// counter and a one-cycle pulse when the accepted level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             sync_lvl;

    // The synchroniser resets to the idle pin level so the inverted view is 0.
    assign sync_lvl = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{ACTIVE_LOW}};
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            press  <= 1'b0;
            if (sync_lvl == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_lvl;
                press <= sync_lvl;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board-level I/O controller: debounced buttons, stretched SOC reset,
// toggled halt request and a mode-selectable LED driver.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int BTN_WIDTH         = 5,
    parameter int LED_WIDTH         = 8,
    parameter int BTN_ACTIVE_LOW    = 0,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int RESET_HOLD_CYCLES = 1024,
    parameter int HEARTBEAT_CYCLES  = 25000000,
    parameter int RESET_BTN         = 0,
    parameter int HALT_BTN          = 1,
    parameter int MODE_BTN          = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_WIDTH-1:0] btn_i,
    input  logic [LED_WIDTH-1:0] soc_leds_i,
    output logic                 soc_rst_n_o,
    output logic                 halt_o,
    output logic [BTN_WIDTH-1:0] btn_level_o,
    output logic [BTN_WIDTH-1:0] btn_press_o,
    output logic [LED_WIDTH-1:0] led_o
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int HB_W   = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam int UPPER_W = LED_WIDTH - 3;

    if (BTN_WIDTH < 3 || LED_WIDTH < 3) begin : g_bad_width
        $error("board_io_ctrl: BTN_WIDTH and LED_WIDTH must both be >= 3");
    end
    if (RESET_BTN >= BTN_WIDTH || HALT_BTN >= BTN_WIDTH || MODE_BTN >= BTN_WIDTH) begin : g_bad_index
        $error("board_io_ctrl: button index out of range");
    end
    if (RESET_BTN == HALT_BTN || RESET_BTN == MODE_BTN || HALT_BTN == MODE_BTN) begin : g_dup_index
        $error("board_io_ctrl: button indices must be distinct");
    end
    if (DEBOUNCE_CYCLES < 2 || RESET_HOLD_CYCLES < 1 || HEARTBEAT_CYCLES < 1) begin : g_bad_timing
        $error("board_io_ctrl: cycle parameters out of range");
    end

    rst_state_t             state;
    logic [HOLD_W-1:0]      hold_cnt;
    led_mode_t              mode;
    logic [HB_W-1:0]        hb_cnt;
    logic                   hb;
    logic [2:0]             status_low;
    logic [LED_WIDTH-1:0]   status_leds;

    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW != 0)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .pin  (btn_i[i]),
            .level(btn_level_o[i]),
            .press(btn_press_o[i])
        );
    end

    // A reset press always beats a halt press, and HOLD keeps halt cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RST_HOLD;
            hold_cnt    <= '0;
            soc_rst_n_o <= 1'b0;
            halt_o      <= 1'b0;
        end else begin
            case (state)
                RST_HOLD: begin
                    halt_o <= 1'b0;
                    if (btn_press_o[RESET_BTN]) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state       <= RST_RUN;
                        hold_cnt    <= '0;
                        soc_rst_n_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RST_RUN: begin
                    if (btn_press_o[RESET_BTN]) begin
                        state       <= RST_HOLD;
                        hold_cnt    <= '0;
                        soc_rst_n_o <= 1'b0;
                        halt_o      <= 1'b0;
                    end else if (btn_press_o[HALT_BTN]) begin
                        halt_o <= ~halt_o;
                    end
                end
                default: begin
                    state       <= RST_HOLD;
                    hold_cnt    <= '0;
                    soc_rst_n_o <= 1'b0;
                    halt_o      <= 1'b0;
                end
            endcase
        end
    end

    // The LED mode survives soft resets; only rst_n returns it to SOC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= LED_SOC;
        end else if (btn_press_o[MODE_BTN]) begin
            mode <= next_led_mode(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

    assign status_low = {~soc_rst_n_o, halt_o, hb};

    if (LED_WIDTH > 3) begin : g_status_upper
        logic [UPPER_W+BTN_WIDTH-1:0] level_ext;
        assign level_ext   = {{UPPER_W{1'b0}}, btn_level_o};
        assign status_leds = {level_ext[UPPER_W-1:0], status_low};
    end else begin : g_status_narrow
        assign status_leds = status_low;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_o <= '0;
        end else begin
            case (mode)
                LED_SOC:    led_o <= soc_leds_i;
                LED_STATUS: led_o <= status_leds;
                default:    led_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: a cycle-level reference model queues
// the expected outputs, a negedge monitor pops and compares them.
module tb_board_io_ctrl;

    localparam int BW    = 5;
    localparam int LW    = 8;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int HB    = 10;
    localparam int OUT_W = 2 + BW + BW + LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] btn = '0;
    logic [BW-1:0] btn_al = '1;
    logic [LW-1:0] soc_leds = 8'hA5;

    logic          soc_rst_n, halt;
    logic [BW-1:0] btn_level, btn_press;
    logic [LW-1:0] led;

    logic          al_soc_rst_n, al_halt;
    logic [BW-1:0] al_level, al_press;
    logic [LW-1:0] al_led;

    logic [OUT_W-1:0] exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  done = 1'b0;

    board_io_ctrl #(
        .BTN_WIDTH(BW), .LED_WIDTH(LW), .BTN_ACTIVE_LOW(0),
        .DEBOUNCE_CYCLES(DEB), .RESET_HOLD_CYCLES(HOLD), .HEARTBEAT_CYCLES(HB),
        .RESET_BTN(0), .HALT_BTN(1), .MODE_BTN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_i(btn), .soc_leds_i(soc_leds),
        .soc_rst_n_o(soc_rst_n), .halt_o(halt), .btn_level_o(btn_level),
        .btn_press_o(btn_press), .led_o(led)
    );

    board_io_ctrl #(
        .BTN_WIDTH(BW), .LED_WIDTH(LW), .BTN_ACTIVE_LOW(1),
        .DEBOUNCE_CYCLES(DEB), .RESET_HOLD_CYCLES(HOLD), .HEARTBEAT_CYCLES(HB),
        .RESET_BTN(0), .HALT_BTN(1), .MODE_BTN(2)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_al), .soc_leds_i(8'hA5),
        .soc_rst_n_o(al_soc_rst_n), .halt_o(al_halt), .btn_level_o(al_level),
        .btn_press_o(al_press), .led_o(al_led)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pin history: synchronised level seen by the debouncer is the pin two edges back.
    bit [BW-1:0] m_h1, m_h2;
    int          m_run[BW];
    bit [BW-1:0] m_level, m_press;
    bit          m_in_run, m_rstn, m_halt, m_hb;
    int          m_elapsed, m_mode, m_hb_cnt;
    bit [LW-1:0] m_led;

    task automatic model_step();
        bit [BW-1:0] synced;
        bit [BW-1:0] new_press;
        if (!rst_n) begin
            m_h1 = '0; m_h2 = '0; m_level = '0; m_press = '0;
            for (int i = 0; i < BW; i++) m_run[i] = 0;
            m_in_run = 1'b0; m_rstn = 1'b0; m_halt = 1'b0; m_hb = 1'b0;
            m_elapsed = 0; m_mode = 0; m_hb_cnt = 0; m_led = '0;
            exp_q.push_back('0);
            return;
        end
        // LEDs reflect the state as it was before this edge.
        if (m_mode == 0)      m_led = soc_leds;
        else if (m_mode == 1) m_led = {m_level, ~m_rstn, m_halt, m_hb};
        else                  m_led = '0;

        if (m_press[2]) m_mode = (m_mode + 1) % 3;

        if (m_in_run) begin
            if (m_press[0]) begin
                m_in_run = 1'b0; m_elapsed = 0; m_rstn = 1'b0; m_halt = 1'b0;
            end else if (m_press[1]) begin
                m_halt = ~m_halt;
            end
        end else begin
            m_halt = 1'b0;
            if (m_press[0]) begin
                m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == HOLD) begin
                    m_in_run = 1'b1; m_elapsed = 0; m_rstn = 1'b1;
                end
            end
        end

        m_hb_cnt++;
        if (m_hb_cnt == HB) begin
            m_hb_cnt = 0;
            m_hb = ~m_hb;
        end

        synced = m_h2;
        m_h2 = m_h1;
        m_h1 = btn;
        new_press = '0;
        for (int i = 0; i < BW; i++) begin
            if (synced[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i]   = synced[i];
                    new_press[i] = synced[i];
                    m_run[i]     = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_press = new_press;

        exp_q.push_back({m_rstn, m_halt, m_level, m_press, m_led});
    endtask

    always @(posedge clk) model_step();

    // ---------------- monitor ----------------
    task automatic monitor_step();
        logic [OUT_W-1:0] e;
        if (done) return;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        if (!rst_n) e = '0;
        check("soc_rst_n_o", soc_rst_n, e[OUT_W-1]);
        check("halt_o", halt, e[OUT_W-2]);
        check("btn_level_o", btn_level, e[OUT_W-3 -: BW]);
        check("btn_press_o", btn_press, e[OUT_W-3-BW -: BW]);
        check("led_o", led, e[LW-1:0]);
    endtask

    always @(negedge clk) monitor_step();

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_btn(input int idx, input int hold_cycles);
        btn[idx] = 1'b1;
        tick(hold_cycles);
        btn[idx] = 1'b0;
        tick(DEB + 4);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        tick(3);
        check("al_level_in_reset", al_level, '0);
        rst_n = 1'b1;
        tick(12);

        // Active-low instance: idle-high pins read as released.
        check("al_level_idle", al_level, '0);
        btn_al[3] = 1'b0;
        seen = 0;
        for (int n = 1; n <= 12 && seen == 0; n++) begin
            tick(1);
            if (al_level[3]) begin
                seen = n;
                check("al_press_pulse", al_press, 5'b01000);
            end
        end
        check("al_accept_latency", seen, 6);
        tick(1);
        check("al_press_single", al_press, '0);
        btn_al[3] = 1'b1;
        tick(DEB + 4);

        // Glitch on halt, then real halt presses.
        press_btn(1, 3);
        press_btn(1, 10);
        press_btn(1, 10);
        press_btn(1, 10);

        // Soft reset while halted, then reset and halt together.
        press_btn(0, 10);
        tick(12);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        tick(10);
        btn = '0;
        tick(14);

        // LED modes: STATUS with heartbeat and button levels, OFF, back to SOC.
        press_btn(2, 10);
        tick(25);
        press_btn(0, 10);
        tick(12);
        press_btn(2, 10);
        press_btn(2, 10);
        tick(5);

        // Randomised button activity and SOC LED patterns.
        for (int k = 0; k < 80; k++) begin
            btn = BW'($urandom);
            soc_leds = LW'($urandom);
            tick($urandom_range(1, 9));
        end
        btn = '0;
        soc_leds = 8'hA5;
        tick(20);

        // Asynchronous reset mid-HOLD and mid-debounce with STATUS mode active.
        press_btn(2, 8);
        btn[0] = 1'b1;
        tick(6);
        btn[0] = 1'b0;
        btn[3] = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_soc_rst_n", soc_rst_n, 1'b0);
        check("async_halt", halt, 1'b0);
        check("async_level", btn_level, '0);
        check("async_press", btn_press, '0);
        check("async_led", led, '0);
        tick(2);
        btn = '0;
        rst_n = 1'b1;
        tick(20);

        done = 1'b1;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board-level I/O controller that sits between the FPGA top-level pins and the Grande_Risco_5_SOC instance. It synchronises and debounces N push-buttons and generates a stretched, button-retriggerable SOC reset. It also produces a toggled halt request and drives the board LEDs through a selectable display mode. It replaces the hard-wired halt tie-off and direct LED connection, so every board top can share one block sized by parameters.

Parameters:
BTN_WIDTH, 5, number of button inputs (>=3)
LED_WIDTH, 8, number of board LEDs (>=3)
BTN_ACTIVE_LOW, 0, 1 = buttons read 0 when pressed; inverted after synchroniser
DEBOUNCE_CYCLES, 500000, cycles a synchronised level must be stable before acceptance (10 ms @ 50 MHz), >=2
RESET_HOLD_CYCLES, 1024, cycles soc_rst_n_o is held low after any reset event, >=1
HEARTBEAT_CYCLES, 25000000, half-period of heartbeat LED in cycles, >=1
RESET_BTN, 0, button index that triggers a soft reset
HALT_BTN, 1, button index that toggles halt_o
MODE_BTN, 2, button index that cycles the LED mode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_i  in  BTN_WIDTH  raw button pins, asynchronous
soc_leds_i  in  LED_WIDTH  LED vector from the SOC
soc_rst_n_o  out  1  registered active-low reset to the SOC
halt_o  out  1  registered halt request to the SOC
btn_level_o  out  BTN_WIDTH  debounced button levels, 1 = pressed
btn_press_o  out  BTN_WIDTH  one-cycle pulse on the debounced rising edge
led_o  out  LED_WIDTH  registered board LED drive

Behaviour:
- rst_n low: all registers clear immediately, without waiting for a clock edge. soc_rst_n_o=0, halt_o=0, btn_level_o=0, btn_press_o=0, led_o=0, LED mode=SOC, heartbeat=0, synchronisers=0 (post-inversion value), debounce counters=0.
- Per button: 2-flop synchroniser, then optional inversion, then debouncer.
- Debouncer:
  - If sync level == stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the sync level and the counter clears.
  - Any glitch back to the stable level restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Latency: a clean pin edge reaches btn_level_o 2+DEBOUNCE_CYCLES cycles later.
- btn_press_o[i] = stable rose this cycle (registered). It is exactly one cycle per accepted press; releases generate no pulse.
- Reset sequencer FSM, states HOLD and RUN:
  - HOLD: soc_rst_n_o=0 and the hold counter counts. After RESET_HOLD_CYCLES cycles in HOLD, go to RUN; soc_rst_n_o=1 on the first RUN cycle.
  - RUN: btn_press_o[RESET_BTN] causes HOLD with the counter cleared.
  - A reset press while already in HOLD restarts the counter.
  - The state after rst_n release is HOLD.
- halt_o:
  - Toggles on btn_press_o[HALT_BTN] only in RUN.
  - Forced to 0 whenever in HOLD.
  - Reset press and halt press in the same cycle: reset wins and halt_o=0.
- LED mode (2-bit):
  - Cycles SOC -> STATUS -> OFF -> SOC on btn_press_o[MODE_BTN].
  - Unaffected by soft reset; cleared only by rst_n.
  - Mode presses are honoured in both HOLD and RUN.
- Heartbeat counter wraps at HEARTBEAT_CYCLES-1 and toggles the heartbeat bit on wrap. It runs in both states.
- led_o is registered, with 1-cycle latency from its sources:
  - SOC mode: soc_leds_i.
  - STATUS mode: bit0=heartbeat, bit1=halt_o, bit2=~soc_rst_n_o. Bits[LED_WIDTH-1:3] = btn_level_o, zero-extended or truncated to fit.
  - OFF mode: all zeros.
- Elaboration-time assertions: the three button indices are distinct and < BTN_WIDTH; BTN_WIDTH >= 3; LED_WIDTH >= 3.

Decomposition:
- Package board_io_pkg holds:
  - led_mode_t enum {LED_SOC, LED_STATUS, LED_OFF}.
  - rst_state_t enum {RST_HOLD, RST_RUN}.
- One sub-module, btn_debounce: a single channel containing the synchroniser, inversion, counter, stable level and press pulse, parametrised by DEBOUNCE_CYCLES and ACTIVE_LOW.
- board_io_ctrl instantiates btn_debounce BTN_WIDTH times with a generate loop.

Test Plan:
Parameters for all scenarios: DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8, HEARTBEAT_CYCLES=10, soc_leds_i=8'hA5.
1. Release rst_n -> soc_rst_n_o low for exactly 8 clocks, then high; halt_o=0; led_o=8'h00 during reset, then 8'hA5 one cycle after release.
2. btn_i[1] high for 3 cycles then low -> no btn_press_o, halt_o stays 0. Then held high 10 cycles -> single btn_press_o[1] pulse 6 cycles after the edge; halt_o=1 the next cycle. A second press -> halt_o=0.
3. In RUN with halt_o=1, press btn 0 -> soc_rst_n_o low for 8 cycles, halt_o=0 the same cycle. Reset and halt pressed in the same cycle -> halt_o stays 0.
4. Press btn 2 -> led_o[0] toggles every 10 cycles, led_o[1]=halt_o, led_o[3] follows btn_level_o[0]. Press again -> led_o=8'h00. Press again -> led_o=8'hA5.
5. Pull rst_n low mid-debounce and mid-HOLD -> all outputs go to 0 with no clock edge needed. After release: no stale press pulse, and the mode is back to SOC.
6. BTN_ACTIVE_LOW=1: btn_i idle all-ones -> btn_level_o=0. Drive one bit low -> press accepted after 6 cycles.
